rename_regfile: RTL and testbench

Parametrised architectural register file with rename (busy/tag) table, multi-lane commit, commit-to-read bypass and branch checkpoints. It sits between the dispatcher, which reads operands and renames destinations, and the ROB, which commits results and signals flushes. It succeeds the single-commit RF with these additions:
- an explicit busy bit, so tag 0 is a legal ROB tag;
- NCOMMIT commit lanes;
- NCKPT snapshots of the rename table for mispredict recovery without a full flush.

---
 rtl/rename_regfile_if.sv | 44 ++++
 rtl/rename_regfile.sv | 123 ++++++++++++
 tb/tb_rename_regfile.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rename_regfile_if.sv
// rename_regfile_if: dispatcher/ROB-facing bundle of the rename register file
interface rename_regfile_if #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int TAG_W   = 4,
  parameter int NCOMMIT = 2,
  parameter int NCKPT   = 4
);
  localparam int RW = $clog2(NREG);
  localparam int CW = $clog2(NCKPT);
  logic                       rdy;
  logic [NCOMMIT-1:0]         cm_valid;
  logic [NCOMMIT*RW-1:0]      cm_rd;
  logic [NCOMMIT*TAG_W-1:0]   cm_tag;
  logic [NCOMMIT*XLEN-1:0]    cm_data;
  logic                       flush;
  logic                       ds_valid;
  logic [RW-1:0]              ds_rd;
  logic [TAG_W-1:0]           ds_tag;
  logic [RW-1:0]              rs1;
  logic [RW-1:0]              rs2;
  logic                       q1_busy;
  logic                       q2_busy;
  logic [TAG_W-1:0]           q1_tag;
  logic [TAG_W-1:0]           q2_tag;
  logic [XLEN-1:0]            v1;
  logic [XLEN-1:0]            v2;
  logic                       ck_take;
  logic [CW-1:0]              ck_id;
  logic                       ck_restore;
  logic [CW-1:0]              ck_rid;
  logic [NCKPT-1:0]           ck_kill;
  logic [NCKPT-1:0]           ck_valid;
  modport master (
    output rdy, cm_valid, cm_rd, cm_tag, cm_data, flush, ds_valid, ds_rd, ds_tag,
           rs1, rs2, ck_take, ck_id, ck_restore, ck_rid, ck_kill,
    input  q1_busy, q2_busy, q1_tag, q2_tag, v1, v2, ck_valid
  );
  modport slave (
    input  rdy, cm_valid, cm_rd, cm_tag, cm_data, flush, ds_valid, ds_rd, ds_tag,
           rs1, rs2, ck_take, ck_id, ck_restore, ck_rid, ck_kill,
    output q1_busy, q2_busy, q1_tag, q2_tag, v1, v2, ck_valid
  );
endinterface

// File: rtl/rename_regfile.sv
// rename_regfile: architectural regfile with busy/tag rename table, multi-lane commit, bypass and checkpoints
module rename_regfile #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int TAG_W   = 4,
  parameter int NCOMMIT = 2,
  parameter int NCKPT   = 4
) (
  input logic             clk,
  input logic             rst,
  rename_regfile_if.slave bus
);
  localparam int RW = $clog2(NREG);
  logic [NCOMMIT-1:0][RW-1:0]            lane_rd;
  logic [NCOMMIT-1:0][TAG_W-1:0]         lane_tag;
  logic [NCOMMIT-1:0][XLEN-1:0]          lane_data;
  logic [NREG-1:0][XLEN-1:0]             regs_q, regs_d;
  logic [NREG-1:0]                       busy_q, busy_d, clr;
  logic [NREG-1:0][TAG_W-1:0]            tag_q, tag_d;
  logic [NCKPT-1:0][NREG-1:0]            sbusy_q, sbusy_d, sclr;
  logic [NCKPT-1:0][NREG-1:0][TAG_W-1:0] stag_q, stag_d;
  logic [NCKPT-1:0]                      ckv_q, ckv_d;
  logic [1:0][RW-1:0]                    rs;
  logic [1:0]                            qb;
  logic [1:0][TAG_W-1:0]                 qt;
  logic [1:0][XLEN-1:0]                  qv;

  assign lane_rd   = bus.cm_rd;
  assign lane_tag  = bus.cm_tag;
  assign lane_data = bus.cm_data;
  assign rs        = {bus.rs2, bus.rs1};

  // a commit retires a register only if its tag is still the newest producer (live table and every slot)
  always_comb begin
    clr  = '0;
    sclr = '0;
    for (int r = 0; r < NREG; r++)
      for (int l = 0; l < NCOMMIT; l++)
        if (bus.cm_valid[l] && lane_rd[l] == RW'(r)) begin
          clr[r] = clr[r] | (busy_q[r] && lane_tag[l] == tag_q[r]);
          for (int s = 0; s < NCKPT; s++)
            sclr[s][r] = sclr[s][r] | (sbusy_q[s][r] && lane_tag[l] == stag_q[s][r]);
        end
  end

  // operand read with same-cycle commit bypass; x0 is never busy and never written so it reads as zero
  always_comb begin
    qb = '0;
    qt = '0;
    qv = '0;
    for (int p = 0; p < 2; p++) begin
      qb[p] = busy_q[rs[p]];
      qt[p] = busy_q[rs[p]] ? tag_q[rs[p]] : '0;
      qv[p] = regs_q[rs[p]];
      for (int l = 0; l < NCOMMIT; l++)
        if (busy_q[rs[p]] && bus.cm_valid[l] && lane_rd[l] == rs[p] && lane_tag[l] == tag_q[rs[p]]) begin
          qb[p] = 1'b0;
          qt[p] = '0;
          qv[p] = lane_data[l];
        end
    end
  end

  assign bus.q1_busy  = qb[0];
  assign bus.q2_busy  = qb[1];
  assign bus.q1_tag   = qt[0];
  assign bus.q2_tag   = qt[1];
  assign bus.v1       = qv[0];
  assign bus.v2       = qv[1];
  assign bus.ck_valid = ckv_q;

  // next state: data commit always lands; table update follows flush > restore > normal
  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    sbusy_d = sbusy_q;
    stag_d  = stag_q;
    ckv_d   = ckv_q;
    for (int l = 0; l < NCOMMIT; l++)
      if (bus.cm_valid[l] && lane_rd[l] != '0) regs_d[lane_rd[l]] = lane_data[l];
    if (bus.flush) begin
      busy_d = '0;
      ckv_d  = '0;
    end else if (bus.ck_restore) begin
      busy_d = sbusy_q[bus.ck_rid] & ~sclr[bus.ck_rid];
      tag_d  = stag_q[bus.ck_rid];
      ckv_d  = ckv_q & ~bus.ck_kill;
      ckv_d[bus.ck_rid] = 1'b0;
    end else begin
      busy_d = busy_q & ~clr;
      for (int s = 0; s < NCKPT; s++)
        if (ckv_q[s]) sbusy_d[s] = sbusy_q[s] & ~sclr[s];
      if (bus.ds_valid && bus.ds_rd != '0) begin
        busy_d[bus.ds_rd] = 1'b1;
        tag_d[bus.ds_rd]  = bus.ds_tag;
      end
      if (bus.ck_take) begin
        sbusy_d[bus.ck_id] = busy_d;
        stag_d[bus.ck_id]  = tag_d;
        ckv_d[bus.ck_id]   = 1'b1;
      end
    end
  end

  // state registers, frozen while rdy is low
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      regs_q  <= '0;
      busy_q  <= '0;
      tag_q   <= '0;
      sbusy_q <= '0;
      stag_q  <= '0;
      ckv_q   <= '0;
    end else if (bus.rdy) begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
      sbusy_q <= sbusy_d;
      stag_q  <= stag_d;
      ckv_q   <= ckv_d;
    end
endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile: directed and random stimulus against a behavioural rename-table model
module tb_rename_regfile;
  localparam int XLEN = 32, NREG = 32, TAG_W = 4, NCOMMIT = 2, NCKPT = 4, RW = 5;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;

  rename_regfile_if #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NCOMMIT(NCOMMIT), .NCKPT(NCKPT)) bus ();
  rename_regfile #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NCOMMIT(NCOMMIT), .NCKPT(NCKPT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [XLEN-1:0]  m_regs [NREG];
  bit               m_busy [NREG];
  logic [TAG_W-1:0] m_tag  [NREG];
  bit               s_busy [NCKPT][NREG];
  logic [TAG_W-1:0] s_tag  [NCKPT][NREG];
  logic [NCKPT-1:0] m_ckv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit lane_hit(input int l, input int r, input logic [TAG_W-1:0] t);
    return bus.cm_valid[l] && int'(bus.cm_rd[l*RW +: RW]) == r && bus.cm_tag[l*TAG_W +: TAG_W] == t;
  endfunction

  function automatic bit committed(input int r, input logic [TAG_W-1:0] t);
    for (int l = 0; l < NCOMMIT; l++)
      if (lane_hit(l, r, t)) return 1'b1;
    return 1'b0;
  endfunction

  // reference model: one update per enabled clock edge, applied rule by rule
  always @(posedge clk or posedge rst) begin
    int k;
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
        m_tag[r]  = '0;
        for (int s = 0; s < NCKPT; s++) begin
          s_busy[s][r] = 1'b0;
          s_tag[s][r]  = '0;
        end
      end
      m_ckv = '0;
    end else if (bus.rdy) begin
      if (bus.flush) begin
        for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
        m_ckv = '0;
      end else if (bus.ck_restore) begin
        k = int'(bus.ck_rid);
        for (int r = 0; r < NREG; r++) begin
          m_busy[r] = s_busy[k][r] && !committed(r, s_tag[k][r]);
          m_tag[r]  = s_tag[k][r];
        end
        m_ckv = m_ckv & ~bus.ck_kill;
        m_ckv[k] = 1'b0;
      end else begin
        for (int r = 0; r < NREG; r++)
          if (m_busy[r] && committed(r, m_tag[r])) m_busy[r] = 1'b0;
        for (int s = 0; s < NCKPT; s++)
          if (m_ckv[s])
            for (int r = 0; r < NREG; r++)
              if (s_busy[s][r] && committed(r, s_tag[s][r])) s_busy[s][r] = 1'b0;
        if (bus.ds_valid && bus.ds_rd != 0) begin
          m_busy[bus.ds_rd] = 1'b1;
          m_tag[bus.ds_rd]  = bus.ds_tag;
        end
        if (bus.ck_take) begin
          for (int r = 0; r < NREG; r++) begin
            s_busy[bus.ck_id][r] = m_busy[r];
            s_tag[bus.ck_id][r]  = m_tag[r];
          end
          m_ckv[bus.ck_id] = 1'b1;
        end
      end
      for (int l = 0; l < NCOMMIT; l++)
        if (bus.cm_valid[l] && bus.cm_rd[l*RW +: RW] != 0)
          m_regs[bus.cm_rd[l*RW +: RW]] = bus.cm_data[l*XLEN +: XLEN];
    end
  end

  task automatic exp_read(input logic [RW-1:0] a, output logic b, output logic [TAG_W-1:0] t, output logic [XLEN-1:0] v);
    b = m_busy[a];
    t = m_busy[a] ? m_tag[a] : '0;
    v = m_regs[a];
    if (m_busy[a])
      for (int l = 0; l < NCOMMIT; l++)
        if (lane_hit(l, int'(a), m_tag[a])) begin
          b = 1'b0;
          t = '0;
          v = bus.cm_data[l*XLEN +: XLEN];
        end
    if (a == 0) begin
      b = 1'b0;
      t = '0;
      v = '0;
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    logic             b;
    logic [TAG_W-1:0] t;
    logic [XLEN-1:0]  v;
    exp_read(bus.rs1, b, t, v);
    chk("m_q1_busy", 32'(bus.q1_busy), 32'(b));
    chk("m_q1_tag", 32'(bus.q1_tag), 32'(t));
    chk("m_v1", bus.v1, v);
    exp_read(bus.rs2, b, t, v);
    chk("m_q2_busy", 32'(bus.q2_busy), 32'(b));
    chk("m_q2_tag", 32'(bus.q2_tag), 32'(t));
    chk("m_v2", bus.v2, v);
    chk("m_ck_valid", 32'(bus.ck_valid), 32'(m_ckv));
  end

  task automatic idle();
    bus.rdy = 1'b1; bus.cm_valid = '0; bus.cm_rd = '0; bus.cm_tag = '0; bus.cm_data = '0;
    bus.flush = 1'b0; bus.ds_valid = 1'b0; bus.ds_rd = '0; bus.ds_tag = '0;
    bus.rs1 = '0; bus.rs2 = '0; bus.ck_take = 1'b0; bus.ck_id = '0;
    bus.ck_restore = 1'b0; bus.ck_rid = '0; bus.ck_kill = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic disp(input int r, input int t);
    bus.ds_valid = 1'b1;
    bus.ds_rd    = RW'(r);
    bus.ds_tag   = TAG_W'(t);
  endtask

  task automatic cm(input int l, input int r, input int t, input logic [XLEN-1:0] d);
    bus.cm_valid[l]              = 1'b1;
    bus.cm_rd[l*RW +: RW]        = RW'(r);
    bus.cm_tag[l*TAG_W +: TAG_W] = TAG_W'(t);
    bus.cm_data[l*XLEN +: XLEN]  = d;
  endtask

  initial begin
    idle();
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_v1", bus.v1, 0);
    chk("rst_ckv", 32'(bus.ck_valid), 0);
    // rename then commit with bypass
    disp(5, 0); bus.rs1 = 5; #1;
    chk("ds_not_visible", 32'(bus.q1_busy), 0);
    nxt();
    bus.rs1 = 5; #1;
    chk("x5_busy", 32'(bus.q1_busy), 1);
    chk("x5_tag", 32'(bus.q1_tag), 0);
    cm(0, 5, 0, 32'hDEAD); #1;
    chk("x5_byp_busy", 32'(bus.q1_busy), 0);
    chk("x5_byp_v", bus.v1, 32'hDEAD);
    nxt();
    bus.rs1 = 5; #1;
    chk("x5_v", bus.v1, 32'hDEAD);
    chk("x5_free", 32'(bus.q1_busy), 0);
    // stale commit
    disp(3, 2); nxt();
    disp(3, 7); nxt();
    cm(0, 3, 2, 32'h11); bus.rs1 = 3; #1;
    chk("stale_nobyp", 32'(bus.q1_busy), 1);
    chk("stale_v0", bus.v1, 0);
    nxt();
    bus.rs1 = 3; #1;
    chk("stale_busy", 32'(bus.q1_busy), 1);
    chk("stale_tag", 32'(bus.q1_tag), 7);
    chk("stale_v", bus.v1, 32'h11);
    // dual lane collision, then commit vs dispatch on same register
    cm(0, 4, 1, 32'hA); cm(1, 4, 1, 32'hB); nxt();
    bus.rs2 = 4; #1;
    chk("dual_v", bus.v2, 32'hB);
    disp(6, 5); nxt();
    cm(0, 6, 5, 32'h66); disp(6, 9); bus.rs1 = 6; #1;
    chk("x6_byp_v", bus.v1, 32'h66);
    nxt();
    bus.rs1 = 6; #1;
    chk("x6_busy", 32'(bus.q1_busy), 1);
    chk("x6_tag", 32'(bus.q1_tag), 9);
    chk("x6_v", bus.v1, 32'h66);
    // checkpoint recovery
    disp(1, 3); bus.ck_take = 1'b1; bus.ck_id = 0; nxt();
    disp(2, 4); cm(0, 1, 3, 32'h33); bus.ck_take = 1'b1; bus.ck_id = 1; nxt();
    bus.rs1 = 1; bus.rs2 = 2; #1;
    chk("ck_two", 32'(bus.ck_valid), 32'b0011);
    chk("x1_v", bus.v1, 32'h33);
    chk("x2_busy", 32'(bus.q2_busy), 1);
    bus.ck_restore = 1'b1; bus.ck_rid = 0; bus.ck_kill = 4'b0010;
    disp(7, 1); bus.ck_take = 1'b1; bus.ck_id = 2; nxt();
    bus.rs1 = 1; bus.rs2 = 2; #1;
    chk("rs_x1", 32'(bus.q1_busy), 0);
    chk("rs_x2", 32'(bus.q2_busy), 0);
    chk("rs_ckv", 32'(bus.ck_valid), 0);
    bus.rs1 = 3; bus.rs2 = 7; #1;
    chk("rs_x3_tag", 32'(bus.q1_tag), 7);
    chk("rs_x7", 32'(bus.q2_busy), 0);
    // flush ignores dispatch and snapshot but still writes commit data
    bus.flush = 1'b1; disp(9, 1); bus.ck_take = 1'b1; bus.ck_id = 3; cm(0, 10, 0, 32'h1010); nxt();
    bus.rs1 = 9; bus.rs2 = 3; #1;
    chk("fl_x9", 32'(bus.q1_busy), 0);
    chk("fl_x3", 32'(bus.q2_busy), 0);
    chk("fl_x3_v", bus.v2, 32'h11);
    chk("fl_ckv", 32'(bus.ck_valid), 0);
    bus.rs1 = 10; #1;
    chk("fl_x10_v", bus.v1, 32'h1010);
    nxt();
    // x0 is immutable
    disp(0, 5); cm(0, 0, 0, 32'hFFFF); bus.rs1 = 0; #1;
    chk("x0_same_v", bus.v1, 0);
    nxt();
    bus.rs1 = 0; #1;
    chk("x0_busy", 32'(bus.q1_busy), 0);
    chk("x0_v", bus.v1, 0);
    // rdy low freezes everything
    bus.rdy = 1'b0; disp(11, 6); cm(0, 12, 0, 32'h12); bus.ck_take = 1'b1; bus.ck_id = 1; nxt();
    bus.rs1 = 11; bus.rs2 = 12; #1;
    chk("stall_x11", 32'(bus.q1_busy), 0);
    chk("stall_x12", bus.v2, 0);
    chk("stall_ckv", 32'(bus.ck_valid), 0);
    // asynchronous reset mid-cycle
    disp(13, 3); cm(0, 14, 0, 32'h5); bus.ck_take = 1'b1; bus.ck_id = 2; nxt();
    bus.rs1 = 13; bus.rs2 = 14; #1;
    chk("pre_rst_busy", 32'(bus.q1_busy), 1);
    chk("pre_rst_v", bus.v2, 32'h5);
    chk("pre_rst_ckv", 32'(bus.ck_valid), 32'b0100);
    rst = 1'b1; #1;
    chk("arst_busy", 32'(bus.q1_busy), 0);
    chk("arst_v", bus.v2, 0);
    chk("arst_ckv", 32'(bus.ck_valid), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    // random traffic on a small register/tag window to force collisions
    for (int i = 0; i < 400; i++) begin
      bus.rdy      = ($urandom_range(0, 7) != 0);
      bus.flush    = ($urandom_range(0, 31) == 0);
      bus.ds_valid = 1'($urandom_range(0, 1));
      bus.ds_rd    = RW'($urandom_range(0, 7));
      bus.ds_tag   = TAG_W'($urandom_range(0, 3));
      for (int l = 0; l < NCOMMIT; l++)
        if ($urandom_range(0, 1) == 1) cm(l, $urandom_range(0, 7), $urandom_range(0, 3), $urandom);
      bus.rs1     = RW'($urandom_range(0, 7));
      bus.rs2     = RW'($urandom_range(0, 7));
      bus.ck_take = ($urandom_range(0, 3) == 0);
      bus.ck_id   = 2'($urandom_range(0, 3));
      bus.ck_rid  = 2'($urandom_range(0, 3));
      bus.ck_kill = 4'($urandom_range(0, 15));
      bus.ck_restore = m_ckv[bus.ck_rid] && ($urandom_range(0, 4) == 0);
      nxt();
    end
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
